// File: rtl/stats_pkg.sv
// Shared encodings for the stats checker: verbosity levels and FSM states.
// Nothing here depends on counter width, so every stats_* file can import it.
package stats_pkg;

   typedef enum logic [2:0] {
      VERB_NONE   = 3'd0,
      VERB_LOW    = 3'd1,
      VERB_MEDIUM = 3'd2,
      VERB_HIGH   = 3'd3,
      VERB_FULL   = 3'd4,
      VERB_DEBUG  = 3'd5
   } verbosity_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } state_e;

endpackage

// File: rtl/stats_checker_if.sv
// Sample bus into the stats checker: one strobe plus an actual/expected word pair per channel.
interface stats_checker_if #(
   parameter int NUM_CH = 4,
   parameter int DATA_W = 16
);
   // There is no ready: a strobed sample is consumed on the edge it is seen while the
   // checker is in RUN, and dropped silently in IDLE, HALT or under clear.
   logic [NUM_CH-1:0]        in_valid;
   logic [NUM_CH*DATA_W-1:0] in_actual;
   logic [NUM_CH*DATA_W-1:0] in_expected;

   modport master (output in_valid, in_actual, in_expected);
   modport slave  (input  in_valid, in_actual, in_expected);
endinterface

// File: rtl/stats_sat_cnt.sv
// Saturating up-counter: adds inc_amt each cycle and clamps at all-ones instead of wrapping.
module stats_sat_cnt #(
   parameter int W       = 32,
   parameter int MAX_INC = 1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         clr,
   input  logic [$clog2(MAX_INC+1)-1:0] inc_amt,
   output logic [W-1:0]                 count
);
   localparam int IW = $clog2(MAX_INC + 1);
   // One guard bit above the wider operand so the sum can never overflow before the clamp.
   localparam int SW = ((W > IW) ? W : IW) + 1;
   localparam logic [SW-1:0] MAX_VAL = {{(SW-W){1'b0}}, {W{1'b1}}};

   logic [SW-1:0] sum;

   assign sum = SW'(count) + SW'(inc_amt);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         count <= '0;
      end else if (sum > MAX_VAL) begin
         count <= '1;
      end else begin
         count <= sum[W-1:0];
      end
   end
endmodule

// File: rtl/stats_checker.sv
// Compares actual against expected words on up to 16 channels, keeps saturating pass/fail
// statistics, captures the first failure and optionally halts after MAX_FAIL failures.
module stats_checker #(
   parameter int NUM_CH   = 4,
   parameter int DATA_W   = 16,
   parameter int CNT_W    = 32,
   parameter int MAX_FAIL = 0
) (
   input  logic                                       clk,
   input  logic                                       rst,
   input  logic                                       start,
   input  logic                                       clear,
   input  logic [2:0]                                 verbosity,
   stats_checker_if.slave                             bus,
   input  logic [$clog2((NUM_CH > 1) ? NUM_CH : 2)-1:0] rd_ch,
   output logic [CNT_W-1:0]                           rd_pass,
   output logic [CNT_W-1:0]                           rd_fail,
   output logic [CNT_W-1:0]                           tot_pass,
   output logic [CNT_W-1:0]                           tot_fail,
   output logic                                       ff_valid,
   output logic [$clog2((NUM_CH > 1) ? NUM_CH : 2)-1:0] ff_ch,
   output logic [DATA_W-1:0]                          ff_exp,
   output logic [DATA_W-1:0]                          ff_act,
   output logic                                       err_event,
   output logic                                       pass_event,
   output logic [1:0]                                 state
);
   import stats_pkg::*;

   localparam int CH_W  = $clog2((NUM_CH > 1) ? NUM_CH : 2);
   localparam int SUM_W = $clog2(NUM_CH + 1);

   state_e            st;
   verbosity_e        verb;
   logic              accept;
   logic [NUM_CH-1:0] pass_vec;
   logic [NUM_CH-1:0] fail_vec;
   logic [SUM_W-1:0]  pass_sum;
   logic [SUM_W-1:0]  fail_sum;
   logic [CH_W-1:0]   first_ch;
   logic [CNT_W:0]    fail_next;
   logic              halt_hit;
   logic [CNT_W-1:0]  ch_pass [NUM_CH];
   logic [CNT_W-1:0]  ch_fail [NUM_CH];

   assign verb   = verbosity_e'(verbosity);
   assign accept = (st == ST_RUN) && !clear;
   assign state  = st;

   // Descending scan so the lowest failing channel is the last one written to first_ch.
   always_comb begin
      pass_vec = '0;
      fail_vec = '0;
      pass_sum = '0;
      fail_sum = '0;
      first_ch = '0;
      for (int k = NUM_CH - 1; k >= 0; k--) begin
         if (accept && bus.in_valid[k]) begin
            if (bus.in_actual[k*DATA_W +: DATA_W] == bus.in_expected[k*DATA_W +: DATA_W]) begin
               pass_vec[k] = 1'b1;
            end else begin
               fail_vec[k] = 1'b1;
               first_ch    = CH_W'(k);
            end
         end
         pass_sum = pass_sum + SUM_W'(pass_vec[k]);
         fail_sum = fail_sum + SUM_W'(fail_vec[k]);
      end
   end

   // Unsaturated next total; the halt decision uses the value this cycle produces.
   assign fail_next = {1'b0, tot_fail} + (CNT_W+1)'(fail_sum);
   assign halt_hit  = (MAX_FAIL > 0) && (fail_sum != '0) &&
                      (fail_next >= (CNT_W+1)'(MAX_FAIL));

   for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      stats_sat_cnt #(.W(CNT_W), .MAX_INC(1)) u_pass (
         .clk(clk), .rst(rst), .clr(clear), .inc_amt(pass_vec[k]), .count(ch_pass[k])
      );
      stats_sat_cnt #(.W(CNT_W), .MAX_INC(1)) u_fail (
         .clk(clk), .rst(rst), .clr(clear), .inc_amt(fail_vec[k]), .count(ch_fail[k])
      );
   end

   stats_sat_cnt #(.W(CNT_W), .MAX_INC(NUM_CH)) u_tot_pass (
      .clk(clk), .rst(rst), .clr(clear), .inc_amt(pass_sum), .count(tot_pass)
   );
   stats_sat_cnt #(.W(CNT_W), .MAX_INC(NUM_CH)) u_tot_fail (
      .clk(clk), .rst(rst), .clr(clear), .inc_amt(fail_sum), .count(tot_fail)
   );

   always_comb begin
      rd_pass = '0;
      rd_fail = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (rd_ch == CH_W'(k)) begin
            rd_pass = ch_pass[k];
            rd_fail = ch_fail[k];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         st         <= ST_IDLE;
         ff_valid   <= 1'b0;
         ff_ch      <= '0;
         ff_exp     <= '0;
         ff_act     <= '0;
         err_event  <= 1'b0;
         pass_event <= 1'b0;
      end else begin
         if (clear) begin
            ff_valid   <= 1'b0;
            ff_ch      <= '0;
            ff_exp     <= '0;
            ff_act     <= '0;
            err_event  <= 1'b0;
            pass_event <= 1'b0;
         end else begin
            if ((fail_vec != '0) && !ff_valid) begin
               ff_valid <= 1'b1;
               ff_ch    <= first_ch;
               ff_exp   <= bus.in_expected[first_ch*DATA_W +: DATA_W];
               ff_act   <= bus.in_actual[first_ch*DATA_W +: DATA_W];
            end
            err_event  <= (fail_vec != '0) && (verb >= VERB_LOW);
            pass_event <= (pass_vec != '0) && (verb >= VERB_HIGH);
         end

         case (st)
            ST_IDLE: if (start)    st <= ST_RUN;
            ST_RUN:  if (halt_hit) st <= ST_HALT;
            ST_HALT: if (clear)    st <= ST_IDLE;
            default:               st <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: doc/stats_checker.md
STATS_CHECKER -- requirements
Module: stats_checker

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 4: number of compare channels, range 1..16.
REQ-002 The block SHALL have parameter DATA_W, default 16: width of each compared word.
REQ-003 The block SHALL have parameter CNT_W, default 32: width of every pass/fail counter.
REQ-004 The block SHALL have parameter MAX_FAIL, default 0: total-fail count that forces HALT; 0 disables halting.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have port start, input, 1 bit: IDLE->RUN request.
REQ-008 The block SHALL have port clear, input, 1 bit: synchronous statistics clear.
REQ-009 The block SHALL have port verbosity, input, 3 bits: event-filter level, NONE=0, LOW=1, MEDIUM=2, HIGH=3, FULL=4, DEBUG=5.
REQ-010 The block SHALL have port in_valid, input, NUM_CH bits: per-channel sample strobe.
REQ-011 The block SHALL have ports in_actual and in_expected, input, NUM_CH*DATA_W bits each: channel k in bits [k*DATA_W +: DATA_W].
REQ-012 The block SHALL have port rd_ch, input, clog2(NUM_CH) bits (minimum 1): per-channel readout select.
REQ-013 The block SHALL have ports rd_pass and rd_fail, output, CNT_W bits each: counters of channel rd_ch, combinational mux.
REQ-014 The block SHALL have ports tot_pass and tot_fail, output, CNT_W bits each: aggregate counters.
REQ-015 The block SHALL have ports ff_valid (1), ff_ch (clog2 NUM_CH), ff_exp (DATA_W) and ff_act (DATA_W), all outputs: first-failure capture.
REQ-016 The block SHALL have ports err_event and pass_event, output, 1 bit each: single-cycle filtered event pulses.
REQ-017 The block SHALL have port state, output, 2 bits: IDLE=0, RUN=1, HALT=2.

Function
REQ-018 FSM transitions SHALL be: IDLE->RUN on start; RUN->HALT when MAX_FAIL>0 and the updated tot_fail>=MAX_FAIL; HALT->IDLE on clear; start SHALL be ignored in RUN and HALT.
REQ-019 Samples SHALL be accepted only in RUN; in_valid in IDLE or HALT SHALL have no effect.
REQ-020 Channel k SHALL pass when in_valid[k] and actual==expected, and fail when in_valid[k] and actual!=expected.
REQ-021 Counters SHALL update on the edge that samples the inputs, i.e. outputs show the new value one cycle after the valid cycle.
REQ-022 tot_pass and tot_fail SHALL each add the popcount of that cycle's passes and fails (0..NUM_CH).
REQ-023 All counters SHALL saturate at 2^CNT_W-1 and never wrap; a partial add near the top SHALL clamp to the maximum.
REQ-024 The first-failure capture SHALL latch on the first failing cycle since reset or clear, taking the lowest-indexed failing channel; ff_valid=1 and the capture SHALL hold until clear or rst.
REQ-025 err_event SHALL pulse one cycle after any failing cycle when verbosity>=LOW.
REQ-026 pass_event SHALL pulse one cycle after any passing cycle when verbosity>=HIGH.
REQ-027 A halt-trigger cycle SHALL still count all of its samples; samples from the following cycle on are ignored.
REQ-028 clear SHALL zero all counters, ff_* and events, and SHALL take priority over a same-cycle sample, which is discarded.
REQ-029 clear SHALL leave state in RUN when in RUN, move HALT to IDLE, and leave IDLE as IDLE.
REQ-030 clear together with start in IDLE SHALL clear and enter RUN.

Reset
REQ-031 rst SHALL force state=IDLE and all counters, ff_valid, ff_ch, ff_exp, ff_act, err_event and pass_event to 0 on the next edge, with priority over all other inputs, including mid-RUN.

Structure
REQ-032 A shared package stats_pkg SHALL hold the verbosity enum (3-bit), the state enum (2-bit) and the CNT_W-independent encodings.
REQ-033 Each counter SHALL be one instance of sub-module stats_sat_cnt, which has parameters W and MAX_INC and ports clk, rst, clr, inc_amt and count; there are 2*NUM_CH+2 instances.

Verification
REQ-034 Bench: start, then ch0..3 valid with all equal, 10 cycles -> tot_pass=40, tot_fail=0, rd_ch=2 gives rd_pass=10, no err_event.
REQ-035 Bench: ch1 and ch3 mismatch in the same cycle (exp 0x00AA, act 0x00AB on ch1) -> ff_ch=1, ff_exp=0x00AA, ff_act=0x00AB, tot_fail=2.
REQ-036 Bench: MAX_FAIL=3, one fail per cycle -> HALT after the third; a fourth fail is ignored, tot_fail=3; clear -> IDLE with counters at 0.
REQ-037 Bench: CNT_W=4, all 4 channels passing for 5 cycles -> tot_pass saturates at 15 and per-channel counters stay at 5.
REQ-038 Bench: verbosity=NONE with a fail -> no err_event; verbosity=LOW -> err_event; verbosity=HIGH with a pass -> pass_event.
REQ-039 Bench: rst asserted mid-RUN while valid is high -> next cycle state=IDLE, all outputs 0, and that sample is not counted.
